armleocpu_trap_sequencer: RTL and testbench



---
 rtl/armleocpu_trap_sequencer_if.sv | 40 ++++
 rtl/armleocpu_trap_sequencer.sv | 155 +++++++++++++++
 tb/tb_armleocpu_trap_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/armleocpu_trap_sequencer_if.sv
// rtl/armleocpu_trap_sequencer_if.sv - trap request handshake and CSR command bus
// slave is the sequencer side; master is the pipeline control plus CSR file side.
`ifndef ARMLEOCPU_CSR_CMD_WIDTH
`define ARMLEOCPU_CSR_CMD_WIDTH 2
`define ARMLEOCPU_CSR_CMD_NONE 2'd0
`define ARMLEOCPU_CSR_CMD_READ 2'd1
`define ARMLEOCPU_CSR_CMD_WRITE 2'd2
`endif

interface armleocpu_trap_sequencer_if;
  logic                                trap_req;
  logic                                trap_ready;
  logic [1:0]                          trap_kind;
  logic [31:0]                         trap_cause;
  logic [31:0]                         trap_epc;
  logic [31:0]                         trap_tval;
  logic                                trap_done;
  logic                                trap_error;
  logic [31:0]                         trap_redirect_pc;
  logic [1:0]                          csr_mcurrent_privilege;
  logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] csr_cmd;
  logic [11:0]                         csr_address;
  logic [31:0]                         csr_writedata;
  logic [31:0]                         csr_readdata;
  logic                                csr_invalid;

  modport slave (
    input  trap_req, trap_kind, trap_cause, trap_epc, trap_tval,
    input  csr_mcurrent_privilege, csr_readdata, csr_invalid,
    output trap_ready, trap_done, trap_error, trap_redirect_pc,
    output csr_cmd, csr_address, csr_writedata
  );

  modport master (
    output trap_req, trap_kind, trap_cause, trap_epc, trap_tval,
    output csr_mcurrent_privilege, csr_readdata, csr_invalid,
    input  trap_ready, trap_done, trap_error, trap_redirect_pc,
    input  csr_cmd, csr_address, csr_writedata
  );
endinterface

// File: rtl/armleocpu_trap_sequencer.sv
// rtl/armleocpu_trap_sequencer.sv - machine-mode trap entry / MRET CSR sequencer
// One CSR command per non-idle state; commands are decoded from state and latched request.
`ifndef ARMLEOCPU_CSR_CMD_WIDTH
`define ARMLEOCPU_CSR_CMD_WIDTH 2
`define ARMLEOCPU_CSR_CMD_NONE 2'd0
`define ARMLEOCPU_CSR_CMD_READ 2'd1
`define ARMLEOCPU_CSR_CMD_WRITE 2'd2
`endif

module armleocpu_trap_sequencer (
  input logic clk,
  input logic rst_n,
  armleocpu_trap_sequencer_if.slave bus
);

  localparam logic [1:0] KIND_EXCEPTION = 2'd0;
  localparam logic [1:0] KIND_INTERRUPT = 2'd1;
  localparam logic [1:0] KIND_MRET      = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_R_MSTATUS,
    S_W_MSTATUS,
    S_R_TARGET
  } state_t;

  state_t      state;
  logic [1:0]  kind_q;
  logic [30:0] cause_q;
  logic [31:2] epc_q;
  logic [31:0] tval_q;
  logic [31:0] mstatus_q;
  logic        done_q;
  logic        error_q;
  logic [31:0] redirect_q;

  logic [`ARMLEOCPU_CSR_CMD_WIDTH-1:0] cmd;
  logic [11:0] address;
  logic [31:0] writedata;

  logic unused_request_bits;
  assign unused_request_bits = ^{bus.trap_cause[31], bus.trap_epc[1:0]};

  wire is_mret = (kind_q == KIND_MRET);
  wire is_irq  = (kind_q == KIND_INTERRUPT);

  always_comb begin
    cmd       = `ARMLEOCPU_CSR_CMD_NONE;
    address   = 12'h000;
    writedata = 32'h0;
    case (state)
      S_W_MEPC: begin
        cmd       = `ARMLEOCPU_CSR_CMD_WRITE;
        address   = 12'h341;
        writedata = {epc_q, 2'b00};
      end
      S_W_MCAUSE: begin
        cmd       = `ARMLEOCPU_CSR_CMD_WRITE;
        address   = 12'h342;
        writedata = {is_irq, cause_q};
      end
      S_W_MTVAL: begin
        cmd       = `ARMLEOCPU_CSR_CMD_WRITE;
        address   = 12'h343;
        writedata = is_irq ? 32'h0 : tval_q;
      end
      S_R_MSTATUS: begin
        cmd     = `ARMLEOCPU_CSR_CMD_READ;
        address = 12'h300;
      end
      S_W_MSTATUS: begin
        cmd       = `ARMLEOCPU_CSR_CMD_WRITE;
        address   = 12'h300;
        writedata = mstatus_q;
        if (is_mret) begin
          writedata[3]     = mstatus_q[7];
          writedata[7]     = 1'b1;
          writedata[12:11] = 2'b00;
        end else begin
          writedata[7]     = mstatus_q[3];
          writedata[3]     = 1'b0;
          writedata[12:11] = bus.csr_mcurrent_privilege;
        end
      end
      S_R_TARGET: begin
        cmd     = `ARMLEOCPU_CSR_CMD_READ;
        address = is_mret ? 12'h341 : 12'h305;
      end
      default: ;
    endcase
  end

  assign bus.csr_cmd          = cmd;
  assign bus.csr_address      = address;
  assign bus.csr_writedata    = writedata;
  assign bus.trap_ready       = (state == S_IDLE);
  assign bus.trap_done        = done_q;
  assign bus.trap_error       = error_q;
  assign bus.trap_redirect_pc = redirect_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kind_q     <= KIND_EXCEPTION;
      cause_q    <= '0;
      epc_q      <= '0;
      tval_q     <= '0;
      mstatus_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.trap_req) begin
          kind_q  <= bus.trap_kind;
          cause_q <= bus.trap_cause[30:0];
          epc_q   <= bus.trap_epc[31:2];
          tval_q  <= bus.trap_tval;
          case (bus.trap_kind)
            KIND_EXCEPTION, KIND_INTERRUPT: state <= S_W_MEPC;
            KIND_MRET:                      state <= S_R_MSTATUS;
            default:                        error_q <= 1'b1;
          endcase
        end
      end else if (bus.csr_invalid) begin
        // The rejected command is the last one; earlier writes stay committed.
        state   <= S_IDLE;
        error_q <= 1'b1;
      end else begin
        case (state)
          S_W_MEPC:    state <= S_W_MCAUSE;
          S_W_MCAUSE:  state <= S_W_MTVAL;
          S_W_MTVAL:   state <= S_R_MSTATUS;
          S_R_MSTATUS: begin
            mstatus_q <= bus.csr_readdata;
            state     <= S_W_MSTATUS;
          end
          S_W_MSTATUS: state <= S_R_TARGET;
          S_R_TARGET: begin
            redirect_q <= bus.csr_readdata;
            done_q     <= 1'b1;
            state      <= S_IDLE;
          end
          default:     state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_trap_sequencer.sv
// tb/tb_armleocpu_trap_sequencer.sv - self-checking bench for the trap sequencer
// A small CSR file answers the DUT; expectations come from a command-list reference model.
`ifndef ARMLEOCPU_CSR_CMD_WIDTH
`define ARMLEOCPU_CSR_CMD_WIDTH 2
`define ARMLEOCPU_CSR_CMD_NONE 2'd0
`define ARMLEOCPU_CSR_CMD_READ 2'd1
`define ARMLEOCPU_CSR_CMD_WRITE 2'd2
`endif

module tb_armleocpu_trap_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  armleocpu_trap_sequencer_if bus ();

  armleocpu_trap_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // CSR file stand-in
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mstatus, m_mtvec;
  int          cmd_cnt = 0;
  logic        inv_en = 1'b0;
  logic [11:0] inv_addr = 12'h0;
  logic        set_en = 1'b0;
  logic [31:0] set_mstatus = 0, set_mtvec = 0, set_mepc = 0;

  always_comb begin
    bus.csr_readdata = 32'h0;
    case (bus.csr_address)
      12'h341: bus.csr_readdata = m_mepc;
      12'h342: bus.csr_readdata = m_mcause;
      12'h343: bus.csr_readdata = m_mtval;
      12'h300: bus.csr_readdata = m_mstatus;
      12'h305: bus.csr_readdata = m_mtvec;
      default: bus.csr_readdata = 32'h0;
    endcase
    bus.csr_invalid = inv_en && (bus.csr_cmd != `ARMLEOCPU_CSR_CMD_NONE) && (bus.csr_address == inv_addr);
  end

  always @(posedge clk) begin
    if (set_en) begin
      m_mstatus <= set_mstatus;
      m_mtvec   <= set_mtvec;
      m_mepc    <= set_mepc;
      m_mcause  <= 32'h0;
      m_mtval   <= 32'h0;
    end else if (bus.csr_cmd == `ARMLEOCPU_CSR_CMD_WRITE && !bus.csr_invalid) begin
      case (bus.csr_address)
        12'h341: m_mepc    <= bus.csr_writedata;
        12'h342: m_mcause  <= bus.csr_writedata;
        12'h343: m_mtval   <= bus.csr_writedata;
        12'h300: m_mstatus <= bus.csr_writedata;
        12'h305: m_mtvec   <= bus.csr_writedata;
        default: ;
      endcase
    end
    if (bus.csr_cmd != `ARMLEOCPU_CSR_CMD_NONE) cmd_cnt <= cmd_cnt + 1;
  end

  // Reference model state
  logic [31:0] e_mepc, e_mcause, e_mtval, e_mstatus, e_mtvec, e_redirect;

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] d;
  } cmd_t;

  function automatic logic [31:0] e_read(input logic [11:0] a);
    case (a)
      12'h341: return e_mepc;
      12'h342: return e_mcause;
      12'h343: return e_mtval;
      12'h300: return e_mstatus;
      12'h305: return e_mtvec;
      default: return 32'h0;
    endcase
  endfunction

  task automatic e_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h341: e_mepc = d;
      12'h342: e_mcause = d;
      12'h343: e_mtval = d;
      12'h300: e_mstatus = d;
      12'h305: e_mtvec = d;
      default: ;
    endcase
  endtask

  task automatic predict(input logic [1:0] kind, input logic [31:0] cause, input logic [31:0] epc,
                         input logic [31:0] tval, input logic [1:0] priv,
                         output bit done, output bit err, output int lat, output int cmds);
    cmd_t q[$];
    logic [31:0] mst;
    done = 0; err = 0; lat = 1; cmds = 0;
    if (kind == 2'd3) begin
      err = 1;
      return;
    end
    if (kind != 2'd2) begin
      mst = (e_mstatus & ~32'h1888) | (((e_mstatus >> 3) & 32'h1) << 7) | (32'(priv) << 11);
      q.push_back('{1'b1, 12'h341, epc & ~32'h3});
      q.push_back('{1'b1, 12'h342, (kind == 2'd1 ? 32'h80000000 : 32'h0) | (cause & 32'h7FFFFFFF)});
      q.push_back('{1'b1, 12'h343, kind == 2'd1 ? 32'h0 : tval});
      q.push_back('{1'b0, 12'h300, 32'h0});
      q.push_back('{1'b1, 12'h300, mst});
      q.push_back('{1'b0, 12'h305, 32'h0});
    end else begin
      mst = (e_mstatus & ~32'h1888) | 32'h80 | (((e_mstatus >> 7) & 32'h1) << 3);
      q.push_back('{1'b0, 12'h300, 32'h0});
      q.push_back('{1'b1, 12'h300, mst});
      q.push_back('{1'b0, 12'h341, 32'h0});
    end
    foreach (q[i]) begin
      if (inv_en && q[i].a == inv_addr) begin
        err = 1; lat = i + 2; cmds = i + 1;
        return;
      end
      if (q[i].wr) e_write(q[i].a, q[i].d);
      else if (i == q.size() - 1) e_redirect = e_read(q[i].a);
    end
    done = 1;
    lat = q.size() + 1;
    cmds = q.size();
  endtask

  task automatic preload(input logic [31:0] mst, input logic [31:0] mtv, input logic [31:0] mep);
    set_mstatus = mst; set_mtvec = mtv; set_mepc = mep; set_en = 1'b1;
    @(negedge clk);
    set_en = 1'b0;
    e_mstatus = mst; e_mtvec = mtv; e_mepc = mep; e_mcause = 0; e_mtval = 0;
  endtask

  // Called just after a negedge; returns at the negedge where done/error is visible.
  task automatic do_trap(input logic [1:0] kind, input logic [31:0] cause, input logic [31:0] epc,
                         input logic [31:0] tval, input logic [1:0] priv, input bit hold);
    bit x_done, x_err;
    int x_lat, x_cmds, c0, lat;
    predict(kind, cause, epc, tval, priv, x_done, x_err, x_lat, x_cmds);
    bus.csr_mcurrent_privilege = priv;
    bus.trap_kind = kind; bus.trap_cause = cause; bus.trap_epc = epc; bus.trap_tval = tval;
    bus.trap_req = 1'b1;
    check_eq("ready_idle", 32'(bus.trap_ready), 32'h1);
    c0 = cmd_cnt;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.trap_kind = 2'd3; bus.trap_cause = ~cause; bus.trap_epc = ~epc; bus.trap_tval = ~tval;
    end else begin
      bus.trap_req = 1'b0;
    end
    lat = 1;
    while (!(bus.trap_done || bus.trap_error) && lat < 20) begin
      if (hold) check_eq("ready_busy", 32'(bus.trap_ready), 32'h0);
      @(negedge clk);
      lat++;
    end
    check_eq("done", 32'(bus.trap_done), 32'(x_done));
    check_eq("error", 32'(bus.trap_error), 32'(x_err));
    check_eq("latency", 32'(lat), 32'(x_lat));
    check_eq("cmd_count", 32'(cmd_cnt - c0), 32'(x_cmds));
    check_eq("redirect", bus.trap_redirect_pc, e_redirect);
    check_eq("cmd_none_end", 32'(bus.csr_cmd), 32'(`ARMLEOCPU_CSR_CMD_NONE));
    check_eq("mepc", m_mepc, e_mepc);
    check_eq("mcause", m_mcause, e_mcause);
    check_eq("mtval", m_mtval, e_mtval);
    check_eq("mstatus", m_mstatus, e_mstatus);
    if (hold) check_eq("ready_done", 32'(bus.trap_ready), 32'h1);
  endtask

  initial begin
    bit          prev_hold;
    bit          hold;
    logic [1:0]  kind;
    logic [11:0] addrs [5];
    addrs[0] = 12'h341; addrs[1] = 12'h342; addrs[2] = 12'h343; addrs[3] = 12'h300; addrs[4] = 12'h305;

    bus.trap_req = 1'b0; bus.trap_kind = 2'd0; bus.trap_cause = 0; bus.trap_epc = 0; bus.trap_tval = 0;
    bus.csr_mcurrent_privilege = 2'd3;
    e_redirect = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(bus.trap_ready), 32'h1);
    check_eq("rst_done", 32'(bus.trap_done), 32'h0);
    check_eq("rst_error", 32'(bus.trap_error), 32'h0);
    check_eq("rst_redirect", bus.trap_redirect_pc, 32'h0);
    check_eq("rst_cmd", 32'(bus.csr_cmd), 32'(`ARMLEOCPU_CSR_CMD_NONE));
    check_eq("rst_addr", 32'(bus.csr_address), 32'h0);
    check_eq("rst_wdata", bus.csr_writedata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exception with MIE set
    preload(32'h8, 32'h100, 32'h0);
    do_trap(2'd0, 32'd2, 32'h80000106, 32'hDEAD, 2'd3, 1'b0);
    check_eq("exc_mepc_const", m_mepc, 32'h80000104);
    check_eq("exc_mstatus_const", m_mstatus, 32'h1880);
    check_eq("exc_redirect_const", bus.trap_redirect_pc, 32'h100);

    // Interrupt
    @(negedge clk);
    do_trap(2'd1, 32'd7, 32'h1234, 32'h55, 2'd3, 1'b0);
    check_eq("irq_mcause_const", m_mcause, 32'h80000007);
    check_eq("irq_mtval_const", m_mtval, 32'h0);

    // MRET
    @(negedge clk);
    preload(32'h1880, 32'h100, 32'h2000);
    do_trap(2'd2, 32'd0, 32'd0, 32'd0, 2'd3, 1'b0);
    check_eq("mret_mstatus_const", m_mstatus, 32'h88);
    check_eq("mret_redirect_const", bus.trap_redirect_pc, 32'h2000);

    // Abort on first write
    @(negedge clk);
    inv_en = 1'b1; inv_addr = 12'h341;
    do_trap(2'd0, 32'd8, 32'h400, 32'h1, 2'd0, 1'b0);
    check_eq("abort_redirect_const", bus.trap_redirect_pc, 32'h2000);
    inv_en = 1'b0;

    // Reserved kind with a held follow-on, then exception held behind an MRET
    @(negedge clk);
    do_trap(2'd3, 32'd1, 32'h10, 32'h2, 2'd3, 1'b1);
    do_trap(2'd0, 32'd4, 32'h3000, 32'h77, 2'd1, 1'b1);
    do_trap(2'd2, 32'd0, 32'd0, 32'd0, 2'd1, 1'b0);

    // Reset during W_MSTATUS
    @(negedge clk);
    preload(32'h8, 32'h100, 32'h0);
    bus.trap_kind = 2'd0; bus.trap_cause = 32'd3; bus.trap_epc = 32'h44; bus.trap_tval = 32'h9;
    bus.csr_mcurrent_privilege = 2'd3; bus.trap_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.trap_req = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_reset_cmd", 32'(bus.csr_cmd), 32'(`ARMLEOCPU_CSR_CMD_WRITE));
    check_eq("pre_reset_addr", 32'(bus.csr_address), 32'h300);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cmd", 32'(bus.csr_cmd), 32'(`ARMLEOCPU_CSR_CMD_NONE));
    check_eq("mid_rst_ready", 32'(bus.trap_ready), 32'h1);
    check_eq("mid_rst_redirect", bus.trap_redirect_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_rst_done", 32'(bus.trap_done), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", 32'(bus.trap_done), 32'h0);
    check_eq("post_rst_mstatus", m_mstatus, 32'h8);
    check_eq("post_rst_mepc", m_mepc, 32'h44);
    e_redirect = 32'h0; e_mepc = 32'h44; e_mcause = 32'd3; e_mtval = 32'h9;
    do_trap(2'd0, 32'd11, 32'h80000000, 32'h0, 2'd3, 1'b0);

    // Randomized traffic
    prev_hold = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!prev_hold) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 2) == 0) preload($urandom, $urandom, $urandom);
      end
      inv_en = ($urandom_range(0, 3) == 0);
      inv_addr = addrs[$urandom_range(0, 4)];
      kind = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0);
      do_trap(kind, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), hold);
      prev_hold = hold;
    end
    inv_en = 1'b0;
    bus.trap_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
